// File: rtl/vga_rx_pkg.sv
// Shared timing defaults, register offsets and STATUS bit positions for the VGA
// timing receiver.
package vga_rx_pkg;

    localparam int DEF_PIX_DIV = 2;
    localparam int DEF_H_TOTAL = 800;
    localparam int DEF_H_SYNC  = 96;
    localparam int DEF_H_BP    = 48;
    localparam int DEF_V_TOTAL = 525;

    typedef enum logic [2:0] {
        REG_CTRL        = 3'd0,
        REG_STATUS      = 3'd1,
        REG_LINE_LEN    = 3'd2,
        REG_HSW         = 3'd3,
        REG_FRAME_LINES = 3'd4,
        REG_CAP_POS     = 3'd5,
        REG_CAP_RGB     = 3'd6,
        REG_FRAME_CNT   = 3'd7
    } reg_ofs_e;

    localparam int ST_HLOCK    = 0;
    localparam int ST_VLOCK    = 1;
    localparam int ST_CAP_DONE = 2;
    localparam int ST_H_ERR    = 3;
    localparam int ST_V_ERR    = 4;
    localparam int ST_HW_ERR   = 5;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/vga_sync_meter.sv
// Edge detector plus saturating counter for one active-low sync; latches the
// period at each falling edge and the low width at each rising edge.
module vga_sync_meter
    import vga_rx_pkg::*;
#(
    parameter bit LATCH_INC = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        en,
    input  logic        sync,
    input  logic        step,
    input  logic        load_one,
    output logic        fall,
    output logic        rise,
    output logic [15:0] cnt,
    output logic [15:0] meas,
    output logic [15:0] period,
    output logic [15:0] width,
    output logic        period_chk,
    output logic        width_chk
);

    logic sync_d;
    logic armed;

    assign fall = sync_d & ~sync;
    assign rise = ~sync_d & sync;
    assign meas = LATCH_INC ? sat_inc(cnt) : cnt;

    // Nothing is trusted until a falling edge has restarted the counter.
    assign period_chk = en & armed & fall;
    assign width_chk  = en & armed & rise;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sync_d <= 1'b0;
            armed  <= 1'b0;
            cnt    <= '0;
            period <= '0;
            width  <= '0;
        end else begin
            sync_d <= sync;
            if (!en) begin
                cnt   <= '0;
                armed <= 1'b0;
            end else begin
                if (fall) begin
                    cnt    <= {15'd0, load_one};
                    armed  <= 1'b1;
                    period <= meas;
                end else if (step) begin
                    cnt <= sat_inc(cnt);
                end
                if (rise) width <= meas;
            end
        end
    end

endmodule

// File: rtl/vga_timing_capture.sv
// AHB-Lite slave that measures an incoming VGA stream's timing, flags deviations
// and captures one pixel at a programmable position.
module vga_timing_capture
    import vga_rx_pkg::*;
#(
    parameter int PIX_DIV = DEF_PIX_DIV,
    parameter int H_TOTAL = DEF_H_TOTAL,
    parameter int H_SYNC  = DEF_H_SYNC,
    parameter int H_BP    = DEF_H_BP,
    parameter int V_TOTAL = DEF_V_TOTAL
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    input  logic        HSYNC_IN,
    input  logic        VSYNC_IN,
    input  logic [7:0]  RGB_IN,
    output logic        IRQ
);

    localparam logic [15:0] LINE_EXP  = 16'(H_TOTAL * PIX_DIV);
    localparam logic [15:0] HSW_EXP   = 16'(H_SYNC * PIX_DIV);
    localparam logic [15:0] FRAME_EXP = 16'(V_TOTAL);
    localparam logic [15:0] X0_HC     = 16'((H_SYNC + H_BP) * PIX_DIV);

    logic       hsync_r, vsync_r;
    logic [7:0] rgb_r;
    logic       acc_q, wr_q;
    reg_ofs_e   ofs_q;
    logic       ctrl_en, ctrl_arm;
    logic [5:2] sticky;
    logic [9:0] cap_x, cap_y;
    logic [1:0] cap_ofs;
    logic [7:0] cap_rgb;
    logic [15:0] frame_cnt;

    logic        h_fall, h_rise, h_pchk, h_wchk;
    logic [15:0] hc, h_meas, line_len, hsw;
    logic        v_fall, v_rise, v_pchk, v_wchk;
    logic [15:0] vc, v_meas, frame_lines, v_width;

    vga_sync_meter #(.LATCH_INC(1'b1)) u_hmeter (
        .HCLK(HCLK), .HRESET(HRESET), .en(ctrl_en), .sync(hsync_r),
        .step(1'b1), .load_one(1'b0), .fall(h_fall), .rise(h_rise),
        .cnt(hc), .meas(h_meas), .period(line_len), .width(hsw),
        .period_chk(h_pchk), .width_chk(h_wchk)
    );

    vga_sync_meter #(.LATCH_INC(1'b0)) u_vmeter (
        .HCLK(HCLK), .HRESET(HRESET), .en(ctrl_en), .sync(vsync_r),
        .step(h_fall), .load_one(h_fall), .fall(v_fall), .rise(v_rise),
        .cnt(vc), .meas(v_meas), .period(frame_lines), .width(v_width),
        .period_chk(v_pchk), .width_chk(v_wchk)
    );

    // Bus handshake: a transfer is taken when HSEL && HREADY && HTRANS[1]; the
    // slave never stalls, so the data phase is always the very next cycle.
    logic wr_en, wr_ctrl, wr_status, wr_cap_pos;
    assign wr_en      = acc_q & wr_q;
    assign wr_ctrl    = wr_en && (ofs_q == REG_CTRL);
    assign wr_status  = wr_en && (ofs_q == REG_STATUS);
    assign wr_cap_pos = wr_en && (ofs_q == REG_CAP_POS);

    logic cap_hit;
    assign cap_hit = ctrl_en && ctrl_arm && (vc == 16'(cap_y) + 16'd1)
                  && (hc == X0_HC + 16'(cap_x) * 16'(PIX_DIV) + {14'd0, cap_ofs});

    logic [5:2] set_c, clr_c;
    always_comb begin
        set_c = '0;
        set_c[ST_CAP_DONE] = cap_hit;
        set_c[ST_H_ERR]    = h_pchk && (h_meas != LINE_EXP);
        set_c[ST_HW_ERR]   = h_wchk && (h_meas != HSW_EXP);
        set_c[ST_V_ERR]    = v_pchk && (v_meas != FRAME_EXP);
        clr_c = '0;
        if (wr_status) clr_c = HWDATA[5:2];
        if (wr_ctrl && HWDATA[1]) clr_c[ST_CAP_DONE] = 1'b1;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            hsync_r   <= 1'b0;
            vsync_r   <= 1'b0;
            rgb_r     <= '0;
            acc_q     <= 1'b0;
            wr_q      <= 1'b0;
            ofs_q     <= REG_CTRL;
            ctrl_en   <= 1'b0;
            ctrl_arm  <= 1'b0;
            sticky    <= '0;
            cap_x     <= '0;
            cap_y     <= '0;
            cap_ofs   <= '0;
            cap_rgb   <= '0;
            frame_cnt <= '0;
        end else begin
            hsync_r <= HSYNC_IN;
            vsync_r <= VSYNC_IN;
            rgb_r   <= RGB_IN;
            acc_q   <= HSEL & HREADY & HTRANS[1];
            wr_q    <= HWRITE;
            ofs_q   <= reg_ofs_e'(HADDR[4:2]);
            // Hardware sets take priority over same-cycle W1C.
            sticky  <= (sticky & ~clr_c) | set_c;
            if (wr_ctrl) begin
                ctrl_en  <= HWDATA[0];
                ctrl_arm <= HWDATA[1];
            end
            if (cap_hit) begin
                ctrl_arm <= 1'b0;
                cap_rgb  <= rgb_r;
            end
            if (wr_cap_pos) begin
                cap_x   <= HWDATA[9:0];
                cap_y   <= HWDATA[25:16];
                cap_ofs <= HWDATA[29:28];
            end
            if (!ctrl_en)    frame_cnt <= '0;
            else if (v_fall) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    logic hlock, vlock;
    assign hlock = (line_len == LINE_EXP);
    assign vlock = (frame_lines == FRAME_EXP);

    always_comb begin
        HRDATA = '0;
        if (acc_q && !wr_q) begin
            case (ofs_q)
                REG_CTRL:        HRDATA = {30'd0, ctrl_arm, ctrl_en};
                REG_STATUS:      HRDATA = {26'd0, sticky, vlock, hlock};
                REG_LINE_LEN:    HRDATA = {16'd0, line_len};
                REG_HSW:         HRDATA = {16'd0, hsw};
                REG_FRAME_LINES: HRDATA = {16'd0, frame_lines};
                REG_CAP_POS:     HRDATA = {2'b00, cap_ofs, 2'b00, cap_y, 6'd0, cap_x};
                REG_CAP_RGB:     HRDATA = {24'd0, cap_rgb};
                REG_FRAME_CNT:   HRDATA = {16'd0, frame_cnt};
                default:         HRDATA = '0;
            endcase
        end
    end

    assign HREADYOUT = 1'b1;
    assign IRQ = sticky[ST_H_ERR] | sticky[ST_V_ERR] | sticky[ST_HW_ERR];

    logic unused_bits;
    assign unused_bits = &{1'b0, HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA[31:30],
                           HWDATA[27:26], HWDATA[15:10], h_rise, v_rise, v_wchk, v_width};

endmodule

// File: tb/tb_vga_timing_capture.sv
// Directed bench: a scaled-down VGA source (20x8 "pixels", PIX_DIV=2) drives the
// receiver while AHB reads check the measured timing, capture and error flags.
module tb_vga_timing_capture;
    import vga_rx_pkg::*;

    localparam int PIX_DIV  = 2;
    localparam int H_TOTAL  = 20;
    localparam int H_SYNC   = 4;
    localparam int H_BP     = 3;
    localparam int V_TOTAL  = 8;
    localparam int LINE_CYC = H_TOTAL * PIX_DIV;   // 40
    localparam int HSW_CYC  = H_SYNC * PIX_DIV;    // 8
    localparam int VS_LINES = 2;
    localparam int CAP_LINE = 5;
    localparam int CAP_PIX  = (H_SYNC + H_BP + 10) * PIX_DIV + 1 + 1;  // 36

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL, HREADY, HWRITE;
    logic [1:0]  HTRANS;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic        HREADYOUT;
    logic        HSYNC_IN, VSYNC_IN;
    logic [7:0]  RGB_IN;
    logic        IRQ;

    vga_timing_capture #(
        .PIX_DIV(PIX_DIV), .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC),
        .H_BP(H_BP), .V_TOTAL(V_TOTAL)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY),
        .HWRITE(HWRITE), .HTRANS(HTRANS), .HADDR(HADDR), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HSYNC_IN(HSYNC_IN),
        .VSYNC_IN(VSYNC_IN), .RGB_IN(RGB_IN), .IRQ(IRQ)
    );

    // clock / reset
    always #5 HCLK = ~HCLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // video source
    bit vid_on = 1'b0;
    int vid_line = 0, vid_pix = 0, vid_abs = 0;
    int stretch_at = -1, stretch_len = LINE_CYC;

    initial begin
        int pix, line, abs_line, cur_len;
        logic [7:0] nz;
        HSYNC_IN = 1'b1; VSYNC_IN = 1'b1; RGB_IN = '0;
        pix = 0; line = 0; abs_line = 0; cur_len = LINE_CYC;
        forever begin
            @(posedge HCLK); #1;
            if (vid_on) begin
                HSYNC_IN = (pix >= HSW_CYC) ? 1'b1 : 1'b0;
                VSYNC_IN = (line >= VS_LINES) ? 1'b1 : 1'b0;
                nz = 8'($urandom_range(0, 255));
                if (nz == 8'h1C) nz = 8'h1D;
                RGB_IN = (line == CAP_LINE && pix == CAP_PIX) ? 8'h1C : nz;
                vid_line = line; vid_pix = pix; vid_abs = abs_line;
                pix++;
                if (pix >= cur_len) begin
                    pix = 0;
                    abs_line++;
                    line = (line + 1 == V_TOTAL) ? 0 : line + 1;
                    cur_len = (abs_line == stretch_at) ? stretch_len : LINE_CYC;
                end
            end
        end
    end

    // driver tasks
    task automatic bus_write(input logic [2:0] ofs, input logic [31:0] data);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {27'd0, ofs, 2'b00};
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
    endtask

    task automatic bus_read(input logic [2:0] ofs, output logic [31:0] data);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {27'd0, ofs, 2'b00};
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        data = HRDATA;
    endtask

    task automatic wait_pos(input int l, input int p, input int budget);
        int n;
        logic hit;
        n = 0;
        do begin
            @(posedge HCLK); #2;
            n++;
            hit = (vid_line == l && vid_pix == p);
        end while (!hit && n < budget);
        check_eq("wait_pos", {31'd0, hit}, 32'd1);
    endtask

    logic [31:0] rd;

    initial begin
        HRESET = 1'b1; HSEL = 1'b0; HREADY = 1'b1; HWRITE = 1'b0;
        HTRANS = 2'b00; HADDR = '0; HWDATA = '0;
        repeat (3) @(posedge HCLK);
        #1;
        check_eq("rst_hrdata", HRDATA, 32'd0);
        check_eq("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check_eq("rst_irq", {31'd0, IRQ}, 32'd0);
        HRESET = 1'b0;
        bus_read(REG_CTRL, rd);      check_eq("rst_ctrl", rd, 32'd0);
        bus_read(REG_STATUS, rd);    check_eq("rst_status", rd, 32'd0);
        bus_read(REG_FRAME_CNT, rd); check_eq("rst_frame_cnt", rd, 32'd0);

        // nominal stream, three frame starts after enabling
        bus_write(REG_CTRL, 32'h1);
        vid_on = 1'b1;
        repeat (2 * V_TOTAL * LINE_CYC + 100) @(posedge HCLK);
        #2;
        bus_read(REG_LINE_LEN, rd);    check_eq("nom_line_len", rd, 32'd40);
        bus_read(REG_HSW, rd);         check_eq("nom_hsw", rd, 32'd8);
        bus_read(REG_FRAME_LINES, rd); check_eq("nom_frame_lines", rd, 32'd8);
        bus_read(REG_STATUS, rd);      check_eq("nom_status", rd, 32'h03);
        bus_read(REG_FRAME_CNT, rd);   check_eq("nom_frame_cnt", rd, 32'd3);
        check_eq("nom_irq", {31'd0, IRQ}, 32'd0);

        // read-only registers ignore writes
        wait_pos(4, 12, 2000);
        bus_write(REG_LINE_LEN, 32'h1234);
        bus_read(REG_LINE_LEN, rd);    check_eq("ro_line_len", rd, 32'd40);
        bus_write(REG_FRAME_CNT, 32'h0);
        bus_read(REG_FRAME_CNT, rd);   check_eq("ro_frame_cnt", rd, 32'd3);
        bus_write(REG_STATUS, 32'h03);
        bus_read(REG_STATUS, rd);      check_eq("ro_status_lock", rd, 32'h03);

        // pixel capture
        wait_pos(0, 0, 2000);
        bus_write(REG_CAP_POS, 32'hFFFF_FFFF);
        bus_read(REG_CAP_POS, rd);     check_eq("cap_pos_mask", rd, 32'h33FF_03FF);
        bus_write(REG_CAP_POS, 32'h1005_000A);
        bus_write(REG_CTRL, 32'h3);
        wait_pos(7, 0, 2000);
        bus_read(REG_CAP_RGB, rd);     check_eq("cap_rgb", rd, 32'h1C);
        bus_read(REG_STATUS, rd);      check_eq("cap_done", rd, 32'h07);
        bus_read(REG_CTRL, rd);        check_eq("cap_arm_clr", rd, 32'h01);
        bus_read(REG_CAP_POS, rd);     check_eq("cap_pos", rd, 32'h1005_000A);
        wait_pos(0, 0, 2000);
        bus_write(REG_CTRL, 32'h3);
        bus_read(REG_STATUS, rd);      check_eq("arm_clr_done", rd, 32'h03);
        bus_write(REG_CTRL, 32'h1);

        // one stretched line (21 pixels)
        wait_pos(3, 0, 2000);
        stretch_at = vid_abs + 1; stretch_len = LINE_CYC + PIX_DIV;
        wait_pos(5, 2, 2000);
        bus_read(REG_LINE_LEN, rd);    check_eq("str_line_len", rd, 32'd42);
        bus_read(REG_STATUS, rd);      check_eq("str_status", rd, 32'h0A);
        check_eq("str_irq", {31'd0, IRQ}, 32'd1);
        bus_write(REG_STATUS, 32'h08);
        bus_read(REG_STATUS, rd);      check_eq("w1c_status", rd, 32'h02);
        check_eq("w1c_irq", {31'd0, IRQ}, 32'd0);
        wait_pos(6, 5, 2000);
        bus_read(REG_STATUS, rd);      check_eq("relock_status", rd, 32'h03);

        // hardware set coincides with W1C of the same bit
        wait_pos(1, 0, 2000);
        stretch_at = vid_abs + 1; stretch_len = LINE_CYC + PIX_DIV;
        wait_pos(2, LINE_CYC + PIX_DIV - 1, 2000);
        bus_write(REG_STATUS, 32'h08);
        bus_read(REG_STATUS, rd);      check_eq("set_wins_status", rd, 32'h0A);
        check_eq("set_wins_irq", {31'd0, IRQ}, 32'd1);
        bus_write(REG_STATUS, 32'h08);
        wait_pos(4, 5, 2000);
        bus_read(REG_STATUS, rd);      check_eq("clean_status", rd, 32'h03);

        // HSYNC held high long enough to saturate the cycle counter
        wait_pos(1, 0, 2000);
        stretch_at = vid_abs + 1; stretch_len = 65600;
        wait_pos(3, 2, 70000);
        bus_read(REG_LINE_LEN, rd);    check_eq("sat_line_len", rd, 32'h0000_FFFF);
        bus_read(REG_STATUS, rd);      check_eq("sat_status", rd, 32'h0A);
        check_eq("sat_irq", {31'd0, IRQ}, 32'd1);

        // reset mid-frame, then re-enable
        wait_pos(3, 10, 2000);
        HRESET = 1'b1;
        repeat (2) @(posedge HCLK);
        #1;
        check_eq("mid_rst_irq", {31'd0, IRQ}, 32'd0);
        check_eq("mid_rst_hrdata", HRDATA, 32'd0);
        check_eq("mid_rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        HRESET = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus_read(3'(i), rd);
            check_eq($sformatf("mid_rst_reg%0d", i), rd, 32'd0);
        end
        bus_write(REG_CTRL, 32'h1);
        wait_pos(0, 0, 2000);
        wait_pos(0, 0, 2000);
        wait_pos(1, 5, 2000);
        bus_read(REG_STATUS, rd);      check_eq("post_rst_status", rd, 32'h03);
        bus_read(REG_FRAME_LINES, rd); check_eq("post_rst_frame_lines", rd, 32'd8);
        bus_read(REG_FRAME_CNT, rd);   check_eq("post_rst_frame_cnt", rd, 32'd2);
        bus_read(REG_LINE_LEN, rd);    check_eq("post_rst_line_len", rd, 32'd40);
        check_eq("post_rst_irq", {31'd0, IRQ}, 32'd0);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
